// File: rtl/fa.sv
// rtl/fa.sv - full adder with registered outputs and capture/carry counters
module fa #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             en,
   output logic             s,
   output logic             co,
   output logic             s_q,
   output logic             co_q,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] carry_cnt
);

   // Combinational path is independent of clk and rst.
   assign s  = a ^ b ^ c;
   assign co = (a & b) | (a & c) | (b & c);

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q       <= 1'b0;
         co_q      <= 1'b0;
         op_cnt    <= '0;
         carry_cnt <= '0;
      end else if (en) begin
         s_q    <= s;
         co_q   <= co;
         op_cnt <= op_cnt + CNT_W'(1);
         if (co) begin
            carry_cnt <= carry_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_fa.sv
// tb/tb_fa.sv - directed self-checking bench for fa
module tb_fa;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a = 1'b0;
   logic       b = 1'b0;
   logic       c = 1'b0;
   logic       en = 1'b0;
   logic       s;
   logic       co;
   logic       s_q;
   logic       co_q;
   logic [7:0] op_cnt;
   logic [7:0] carry_cnt;

   int n_total = 0;
   int n_pass  = 0;

   fa #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .b         (b),
      .c         (c),
      .en        (en),
      .s         (s),
      .co        (co),
      .s_q       (s_q),
      .co_q      (co_q),
      .op_cnt    (op_cnt),
      .carry_cnt (carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string tag, input logic e_s, input logic e_co,
                             input logic [7:0] e_op, input logic [7:0] e_cy);
      check({tag, " s_q"}, 8'(s_q), 8'(e_s));
      check({tag, " co_q"}, 8'(co_q), 8'(e_co));
      check({tag, " op_cnt"}, op_cnt, e_op);
      check({tag, " carry_cnt"}, carry_cnt, e_cy);
   endtask

   // Bit i holds the result for {a,b,c} == i.
   logic [7:0] s_tab  = 8'b1001_0110;
   logic [7:0] co_tab = 8'b1110_1000;
   logic [2:0] v;

   initial begin
      tick();
      check_regs("reset", 1'b0, 1'b0, 8'd0, 8'd0);

      // Truth table while held in reset with the clock running.
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         {a, b, c} = v;
         #10;
         check($sformatf("tt s %0d", i), 8'(s), 8'(s_tab[i]));
         check($sformatf("tt co %0d", i), 8'(co), 8'(co_tab[i]));
      end
      check_regs("reset hold", 1'b0, 1'b0, 8'd0, 8'd0);

      // Single capture of 1+1+1.
      rst = 1'b0;
      {a, b, c} = 3'b111;
      en = 1'b1;
      tick();
      check_regs("cap111", 1'b1, 1'b1, 8'd1, 8'd1);

      // Hold with en low while inputs toggle.
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         v = 3'(i + 1);
         {a, b, c} = v;
         tick();
         check($sformatf("hold s %0d", i), 8'(s), 8'(s_tab[i + 1]));
         check($sformatf("hold co %0d", i), 8'(co), 8'(co_tab[i + 1]));
      end
      check_regs("hold", 1'b1, 1'b1, 8'd1, 8'd1);

      en = 1'b1;
      {a, b, c} = 3'b101;
      tick();
      check_regs("cap101", 1'b0, 1'b1, 8'd2, 8'd2);
      {a, b, c} = 3'b100;
      tick();
      check_regs("cap100", 1'b1, 1'b0, 8'd3, 8'd2);

      // op_cnt wrap with no carries.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 255; i++) tick();
      check_regs("pre wrap", 1'b1, 1'b0, 8'd255, 8'd0);
      tick();
      check_regs("op wrap", 1'b1, 1'b0, 8'd0, 8'd0);

      // Both counters wrap together when every capture carries.
      {a, b, c} = 3'b110;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 255; i++) tick();
      check_regs("pre cwrap", 1'b0, 1'b1, 8'd255, 8'd255);
      tick();
      check_regs("carry wrap", 1'b0, 1'b1, 8'd0, 8'd0);
      tick();
      check_regs("after wrap", 1'b0, 1'b1, 8'd1, 8'd1);

      // Reset overrides en mid-operation.
      tick();
      rst = 1'b1;
      #1;
      check("rst comb s", 8'(s), 8'd0);
      check("rst comb co", 8'(co), 8'd1);
      check_regs("pre rst", 1'b0, 1'b1, 8'd2, 8'd2);
      tick();
      check_regs("rst+en", 1'b0, 1'b0, 8'd0, 8'd0);

      // Resume counting on first enabled edge after reset.
      rst = 1'b0;
      en = 1'b0;
      tick();
      check_regs("idle", 1'b0, 1'b0, 8'd0, 8'd0);
      en = 1'b1;
      tick();
      check_regs("resume", 1'b0, 1'b1, 8'd1, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fa.md
FA -- requirements
Module: fa

Interface
REQ-001 Parameter: CNT_W, default 8, width of the operation and carry counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 c  input  1  carry-in bit.
REQ-007 en  input  1  registered-capture enable.
REQ-008 s  output  1  combinational sum.
REQ-009 co  output  1  combinational carry-out.
REQ-010 s_q  output  1  registered sum.
REQ-011 co_q  output  1  registered carry-out.
REQ-012 op_cnt  output  CNT_W  count of enabled capture cycles.
REQ-013 carry_cnt  output  CNT_W  count of enabled captures with carry-out 1.

Function
REQ-014 s SHALL equal a XOR b XOR c, purely combinational, no clock or reset dependence.
REQ-015 co SHALL equal (a AND b) OR (a AND c) OR (b AND c), purely combinational.
REQ-016 s and co SHALL settle within the same time step as any input change; they are valid with clk idle and rst asserted.
REQ-017 On a rising edge with rst=0 and en=1: s_q <= s and co_q <= co; latency exactly 1 cycle.
REQ-018 On a rising edge with rst=0 and en=0: s_q, co_q, op_cnt, carry_cnt SHALL hold.
REQ-019 On a rising edge with rst=0 and en=1: op_cnt SHALL increment by 1, modulo 2^CNT_W (wrap from all-ones to 0).
REQ-020 On a rising edge with rst=0, en=1 and co=1: carry_cnt SHALL increment by 1, modulo 2^CNT_W; otherwise carry_cnt holds.
REQ-021 The two counters SHALL wrap independently; a wrap SHALL NOT affect s_q or co_q.
REQ-022 Inputs a, b, c and en are sampled only at the rising edge for registered outputs; no handshake, en may be asserted every cycle.

Reset
REQ-023 rst=1 at a rising edge SHALL set s_q=0, co_q=0, op_cnt=0 and carry_cnt=0, overriding en.
REQ-024 Reset SHALL NOT affect s or co, which continue to follow a, b and c.
REQ-025 Reset asserted mid-operation SHALL take effect at the next rising edge only; deassertion SHALL resume counting on the first edge with en=1.

Verification
REQ-026 Exhaustive truth table, 10 ns per vector, (a,b,c) 000..111 -> (s,co) = 00,10,10,01,10,01,01,11.
REQ-027 Reset then en=1 with a=1,b=1,c=1 for one edge -> after the edge s_q=1, co_q=1, op_cnt=1, carry_cnt=1.
REQ-028 en=0 while inputs toggle for 5 edges -> s_q, co_q and both counters unchanged, while s and co still track the inputs.
REQ-029 CNT_W=8, en=1 with a=1,b=0,c=0 for 256 edges after reset -> op_cnt wraps to 0, carry_cnt stays 0.
REQ-030 rst=1 and en=1 on the same edge with a=b=1 -> s_q=0, co_q=0, counters 0; s=0, co=1 combinationally.
